// File: rtl/prog_ctr.sv
// prog_ctr: program counter and fetch sequencer.
//
// This block holds the current instruction address. In RUN it advances the
// address every cycle. A taken relative branch adds the signed offset from the
// branch-target lookup table to the branch's own address. The block also runs
// the IDLE/RUN/DONE handshake with the top level, and keeps saturating cycle
// and taken-branch counters for performance reporting.
//
// Parameters
//   D   PC and branch-offset width
//   CW  cycle counter width
//   BW  taken-branch counter width
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Start        load StartAddr, clear counters, enter RUN (any state)
//   StartAddr    first instruction address
//   BranchRel    current instruction is a relative conditional branch
//   Taken        branch condition, only meaningful with BranchRel
//   Target       two's-complement offset relative to the branch address
//   Halt         current instruction terminates the program
//   Stall        freeze the PC this cycle
//   ProgCtr      current instruction address
//   Running      high while in RUN
//   Done         high while in DONE
//   CycleCount   RUN cycles since the last Start (saturating)
//   BranchCount  taken branches since the last Start (saturating)
module prog_ctr #(
  parameter int D  = 12,
  parameter int CW = 16,
  parameter int BW = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [D-1:0]  StartAddr,
  input  logic          BranchRel,
  input  logic          Taken,
  input  logic [D-1:0]  Target,
  input  logic          Halt,
  input  logic          Stall,
  output logic [D-1:0]  ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount,
  output logic [BW-1:0] BranchCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic [D-1:0]  pcNext;
  logic [CW-1:0] cycleNext;
  logic [BW-1:0] branchNext;

  // State and datapath registers. Every output comes straight from here or
  // from a decode of the state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      ProgCtr     <= '0;
      CycleCount  <= '0;
      BranchCount <= '0;
    end else begin
      state       <= stateNext;
      ProgCtr     <= pcNext;
      CycleCount  <= cycleNext;
      BranchCount <= branchNext;
    end
  end

  // Next-state and next-datapath decision. Start overrides everything. In RUN
  // the order is Stall, Halt, taken branch, then sequential. The cycle counter
  // counts every RUN cycle, including stall and halt cycles. Both counters stop
  // at all-ones instead of wrapping. PC arithmetic wraps modulo 2^D. Target is
  // already D bits wide, so an unsigned add gives the signed result.
  always_comb begin
    stateNext  = state;
    pcNext     = ProgCtr;
    cycleNext  = CycleCount;
    branchNext = BranchCount;

    if (Start) begin
      stateNext  = RUN;
      pcNext     = StartAddr;
      cycleNext  = '0;
      branchNext = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (CycleCount != '1) begin
            cycleNext = CycleCount + CW'(1);
          end
          if (Stall) begin
            pcNext = ProgCtr;
          end else if (Halt) begin
            stateNext = DONE;
          end else if (BranchRel && Taken) begin
            pcNext = ProgCtr + Target;
            if (BranchCount != '1) begin
              branchNext = BranchCount + BW'(1);
            end
          end else begin
            pcNext = ProgCtr + D'(1);
          end
        end
        IDLE: begin
          stateNext = IDLE;
        end
        DONE: begin
          stateNext = DONE;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == DONE);

endmodule
